// File: rtl/instr_rom_fetch.sv
// Instruction ROM with a valid/ready fetch port, programmable response latency and flush.
// Optional macro IMEM_FAULT_CHECK_EN enables misalignment / out-of-range fault reporting.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instr_rom_fetch #(
  parameter int unsigned                 DEPTH    = 256,
  parameter int unsigned                 LATENCY  = 1,
  parameter logic [`INSTR_WIDTH-1:0]     NOP_WORD = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [`DATA_WIDTH-1:0]  req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [`INSTR_WIDTH-1:0] rsp_instr,
  output logic                    rsp_fault,
  input  logic                    flush
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [`DATA_WIDTH-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]        word_idx;
  logic                    fetch_fault;

  // Fixed boot image: first four words are a short addi sequence, the rest are NOPs.
  function automatic logic [`INSTR_WIDTH-1:0] rom_word(input logic [IDX_W-1:0] idx);
    int unsigned i;
    logic [`INSTR_WIDTH-1:0] w;
    i = 32'(idx);
    w = NOP_WORD;
    if      (i == 0) w = 32'h00100093;
    else if (i == 1) w = 32'h00200113;
    else if (i == 2) w = 32'h00308193;
    else if (i == 3) w = 32'h00110213;
    return w;
  endfunction

  assign word_idx = addr_q[IDX_W+1:2];

`ifdef IMEM_FAULT_CHECK_EN
  assign fetch_fault = (addr_q[1:0] != 2'b00) ||
                       ((addr_q >> 2) >= `DATA_WIDTH'(DEPTH));
`else
  // Byte offset and bits above the word index are don't-care: addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[1:0], addr_q[`DATA_WIDTH-1:IDX_W+2]};
  assign fetch_fault      = 1'b0;
`endif

  assign req_ready = rst_n && (state_q == IDLE) && !flush;
  assign rsp_valid = (state_q == RESP);
  assign rsp_fault = rsp_valid && fetch_fault;
  assign rsp_instr = (rsp_valid && !fetch_fault) ? rom_word(word_idx) : NOP_WORD;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_d = req_addr;
            if (LATENCY == 1) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_d = RESP;
          else             cnt_d   = cnt_q - 1'b1;
        end
        RESP: begin
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

endmodule
